// File: rtl/elevator_pkg.sv
// Shared encodings and sizes for the elevator controller and the floor request scheduler.
package elevator_pkg;
    localparam int FLOOR_W        = 4;
    localparam int DEF_NUM_FLOORS = 10;

    typedef logic [FLOOR_W-1:0] floor_t;

    // Encodings shared with elevator_state_machine.
    typedef enum logic [1:0] {
        HOLD       = 2'b00,
        SERVE_UP   = 2'b10,
        SERVE_DOWN = 2'b11
    } sched_state_t;
endpackage

// File: rtl/floor_request_scheduler_if.sv
// Button/controller bundle between the scheduler (slave) and its surroundings (master).
interface floor_request_scheduler_if
    import elevator_pkg::*;
#(
    parameter int NUM_FLOORS = DEF_NUM_FLOORS
);
    logic [NUM_FLOORS-1:0] call_btn;
    floor_t                current_floor;
    logic                  elevator_idle;
    floor_t                requested_floor;
    logic [NUM_FLOORS-1:0] pending;
    logic                  dir_up;

    modport master (
        output call_btn, current_floor, elevator_idle,
        input  requested_floor, pending, dir_up
    );

    modport slave (
        input  call_btn, current_floor, elevator_idle,
        output requested_floor, pending, dir_up
    );
endinterface

// File: rtl/btn_debounce.sv
// One call button: 2-flop synchronizer, plus a stability counter when BTN_DEBOUNCE_EN is defined.
module btn_debounce #(
    parameter logic [15:0] DEBOUNCE_CYCLES = 16'd50000
) (
    input  logic clk,
    input  logic reset,
    input  logic i_btn,
    output logic o_level
);
    logic r_sync1, r_sync2;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
        end else begin
            r_sync1 <= i_btn;
            r_sync2 <= r_sync1;
        end
    end

`ifdef BTN_DEBOUNCE_EN
    logic        r_last, r_level;
    logic [15:0] r_cnt;

    // Any change restarts the count; the level moves only after a full stable window.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_last  <= 1'b0;
            r_level <= 1'b0;
            r_cnt   <= '0;
        end else begin
            r_last <= r_sync2;
            if (r_sync2 != r_last)
                r_cnt <= '0;
            else if (r_cnt != DEBOUNCE_CYCLES)
                r_cnt <= r_cnt + 16'd1;
            else
                r_level <= r_last;
        end
    end

    assign o_level = r_level;
`else
    logic w_unused_db;
    assign w_unused_db = ^DEBOUNCE_CYCLES;
    assign o_level     = r_sync2;
`endif
endmodule

// File: rtl/floor_request_scheduler.sv
// SCAN-order floor request scheduler feeding elevator_state_machine.
// Optional input filtering: define BTN_DEBOUNCE_EN.
module floor_request_scheduler
    import elevator_pkg::*;
#(
    parameter int          NUM_FLOORS      = DEF_NUM_FLOORS,
    parameter logic [15:0] DEBOUNCE_CYCLES = 16'd50000
) (
    input  logic                      clk,
    input  logic                      reset,
    floor_request_scheduler_if.slave  bus
);
    localparam floor_t LAST_FLOOR = floor_t'(NUM_FLOORS - 1);

    logic [NUM_FLOORS-1:0] w_level, w_rise, w_clr, w_pend_nxt;
    logic [NUM_FLOORS-1:0] r_level_q, r_pending;
    sched_state_t          r_state, w_state_nxt;
    floor_t                r_req, w_req_nxt, w_cur;
    logic                  r_dir, w_dir_nxt, w_cur_ok, w_idle;
    logic                  w_any_above, w_any_below;
    floor_t                w_above_lo, w_below_hi;

    for (genvar f = 0; f < NUM_FLOORS; f++) begin : g_btn
        btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_btn (
            .clk     (clk),
            .reset   (reset),
            .i_btn   (bus.call_btn[f]),
            .o_level (w_level[f])
        );
    end

    assign w_cur    = bus.current_floor;
    assign w_idle   = bus.elevator_idle;
    assign w_cur_ok = (w_cur <= LAST_FLOOR);
    assign w_rise   = w_level & ~r_level_q;

    // Clear is applied after the press so a same-floor press while parked is dropped.
    always_comb begin
        w_clr = '0;
        for (int f = 0; f < NUM_FLOORS; f++)
            w_clr[f] = w_idle && (w_cur == floor_t'(f));
        w_pend_nxt = (r_pending | w_rise) & ~w_clr;
    end

    always_comb begin
        w_any_above = 1'b0;
        w_above_lo  = '0;
        w_any_below = 1'b0;
        w_below_hi  = '0;
        for (int f = NUM_FLOORS - 1; f >= 0; f--) begin
            if (r_pending[f] && floor_t'(f) > w_cur) begin
                w_any_above = 1'b1;
                w_above_lo  = floor_t'(f);
            end
        end
        for (int f = 0; f < NUM_FLOORS; f++) begin
            if (r_pending[f] && floor_t'(f) < w_cur) begin
                w_any_below = 1'b1;
                w_below_hi  = floor_t'(f);
            end
        end
    end

    // While moving, only a strictly closer pick-up ahead may replace the target.
    always_comb begin
        w_state_nxt = r_state;
        w_req_nxt   = r_req;
        if (w_cur_ok) begin
            case (r_state)
                HOLD: begin
                    if (r_pending == '0) begin
                        w_req_nxt = w_cur;
                    end else if (w_any_above) begin
                        w_state_nxt = SERVE_UP;
                        w_req_nxt   = w_above_lo;
                    end else begin
                        w_state_nxt = SERVE_DOWN;
                        w_req_nxt   = w_any_below ? w_below_hi : w_cur;
                    end
                end
                SERVE_UP: begin
                    if (!w_idle) begin
                        if (w_any_above && w_above_lo < r_req)
                            w_req_nxt = w_above_lo;
                    end else if (w_any_above) begin
                        w_req_nxt = w_above_lo;
                    end else if (w_any_below) begin
                        w_state_nxt = SERVE_DOWN;
                        w_req_nxt   = w_below_hi;
                    end else begin
                        w_state_nxt = HOLD;
                        w_req_nxt   = w_cur;
                    end
                end
                SERVE_DOWN: begin
                    if (!w_idle) begin
                        if (w_any_below && w_below_hi > r_req)
                            w_req_nxt = w_below_hi;
                    end else if (w_any_below) begin
                        w_req_nxt = w_below_hi;
                    end else if (w_any_above) begin
                        w_state_nxt = SERVE_UP;
                        w_req_nxt   = w_above_lo;
                    end else begin
                        w_state_nxt = HOLD;
                        w_req_nxt   = w_cur;
                    end
                end
                default: w_state_nxt = HOLD;
            endcase
        end
        w_dir_nxt = (w_state_nxt == SERVE_UP)   ? 1'b1 :
                    (w_state_nxt == SERVE_DOWN) ? 1'b0 : r_dir;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= HOLD;
            r_req     <= '0;
            r_dir     <= 1'b1;
            r_pending <= '0;
            r_level_q <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_req     <= w_req_nxt;
            r_dir     <= w_dir_nxt;
            r_pending <= w_pend_nxt;
            r_level_q <= w_level;
        end
    end

    assign bus.requested_floor = r_req;
    assign bus.pending         = r_pending;
    assign bus.dir_up          = r_dir;
endmodule
